writeback_register_file: RTL and testbench
==========================================

Name: writeback_register_file

Overview:
- Write-back stage plus architectural register file; consumes the outputs of the MEM/WB pipeline register.
- Selects write-back data (memory load vs ALU result) and commits it to a 32 x 32-bit register file.
- Serves two combinational read ports for the decode stage.
- Exposes the selected write-back value and destination for forwarding, and a commit counter for debug/perf.

Parameters:
- DATA_W, 32, register and data width.
- NUM_REGS, 32, number of architectural registers; index width is 5 bits.
- COUNT_W, 16, width of the commit counter.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- WriteBackEnableInput  input  1  write-back request from MEM/WB.
- MemoryReadEnableInput  input  1  1 = select load data, 0 = select ALU result.
- ALUResultInput  input  DATA_W  ALU result from MEM/WB.
- MemoryReadData  input  DATA_W  load data from MEM/WB.
- DestinationRegisterInput  input  5  destination register index.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  DATA_W  read port 1 data.
- ReadData2  output  DATA_W  read port 2 data.
- WriteBackData  output  DATA_W  selected write-back value (combinational), used for forwarding.
- WriteBackRegister  output  5  DestinationRegisterInput when the write is accepted, else 0.
- WriteBackCommit  output  1  1 when a write is accepted this cycle (combinational).
- CommitCount  output  COUNT_W  registered count of accepted writes.

Behaviour:
- Data select: WriteBackData = MemoryReadEnableInput ? MemoryReadData : ALUResultInput, at full DATA_W width, no extension logic.
- Write acceptance: accept = WriteBackEnableInput && (DestinationRegisterInput != 0).
- WriteBackCommit = accept.
- WriteBackRegister = accept ? DestinationRegisterInput : 5'd0.
- Register write: on posedge clk with accept = 1, regs[DestinationRegisterInput] <= WriteBackData. The new value is visible on the read ports in the following cycle; latency is 1 edge.
- Register 0: hardwired zero. Writes to index 0 are dropped, are not counted, and do not raise WriteBackCommit. Reads of index 0 always return 0.
- Enable low: DestinationRegisterInput and both data inputs are ignored. No state changes.
- Reads: ReadData1/2 = regs[ReadRegister1/2], combinational and asynchronous.
- Both read ports may address the same register and return identical data.
- Counter: CommitCount increments by 1 on each posedge with accept = 1. It wraps from 2^COUNT_W-1 to 0 with no flag.
- Reset: on the falling edge of Reset, asynchronously and without waiting for clk:
  - all regs cleared to 0;
  - CommitCount cleared to 0.
- Outputs during reset:
  - ReadData1/2 read 0.
  - WriteBackData/WriteBackRegister/WriteBackCommit stay combinational from the inputs, but no write commits while Reset = 0.
- Reset deassertion: the first accepted write occurs at the first posedge with Reset = 1.
- Reset mid-operation: a write pending on the same edge as reset assertion is lost; the register stays 0.
- Simultaneous read and write of the same register: the result depends on the optional feature.
- No stall or handshake: every cycle with accept = 1 commits. The upstream pipeline register guarantees at most one write per cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - If accept = 1 and ReadRegisterN == DestinationRegisterInput, ReadDataN returns WriteBackData in the same cycle (write-before-read).
  - Index 0 is never bypassed.
  - Bypass is suppressed while Reset = 0.
- Undefined:
  - Reads return the stored (old) value during the write cycle; the new value appears after the edge.
  - The hazard unit must cover the extra cycle.

Test Plan:
- Reset: hold Reset = 0 with random inputs for 3 cycles -> ReadData1/2 = 0 for all indices, CommitCount = 0, and no register changes even with WriteBackEnableInput = 1.
- ALU write-back: enable = 1, MemoryReadEnableInput = 0, ALUResultInput = 0x1234_5678, dest = 5, then read reg 5 next cycle -> ReadData1 = 0x1234_5678, CommitCount = 1, WriteBackCommit = 1 and WriteBackRegister = 5 during the write cycle.
- Load select: MemoryReadEnableInput = 1, MemoryReadData = 0xDEAD_BEEF, ALUResultInput = 0x0000_0001, dest = 31 -> reg 31 = 0xDEAD_BEEF and WriteBackData = 0xDEAD_BEEF.
- Register 0 and disabled writes: enable = 1, dest = 0, data = 0xFFFF_FFFF -> reg 0 reads 0, WriteBackCommit = 0, CommitCount unchanged. Then enable = 0, dest = 7, data = 0xAAAA_AAAA -> reg 7 unchanged.
- Same-cycle read/write: reg 9 = 0x11, write 0x22 to reg 9 while ReadRegister2 = 9 -> ReadData2 = 0x22 in that cycle with WB_BYPASS_EN, 0x11 without; 0x22 next cycle in both builds.
- Counter wrap and async reset: with COUNT_W = 4, perform 17 accepted writes -> CommitCount = 1. Then drop Reset between clock edges -> counter and all regs read 0 immediately, before the next posedge.

Source files
------------

// File: rtl/writeback_register_file_if.sv
// MEM/WB write-back bus and decode read-port bus.
// The upstream pipeline side is master; the register file is slave.
interface writeback_register_file_if #(
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16
);
  logic              WriteBackEnableInput;
  logic              MemoryReadEnableInput;
  logic [DATA_W-1:0] ALUResultInput;
  logic [DATA_W-1:0] MemoryReadData;
  logic [4:0]        DestinationRegisterInput;
  logic [4:0]        ReadRegister1;
  logic [4:0]        ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] WriteBackData;
  logic [4:0]        WriteBackRegister;
  logic              WriteBackCommit;
  logic [COUNT_W-1:0] CommitCount;

  modport master (
    output WriteBackEnableInput,
    output MemoryReadEnableInput,
    output ALUResultInput,
    output MemoryReadData,
    output DestinationRegisterInput,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2,
    input  WriteBackData,
    input  WriteBackRegister,
    input  WriteBackCommit,
    input  CommitCount
  );

  modport slave (
    input  WriteBackEnableInput,
    input  MemoryReadEnableInput,
    input  ALUResultInput,
    input  MemoryReadData,
    input  DestinationRegisterInput,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2,
    output WriteBackData,
    output WriteBackRegister,
    output WriteBackCommit,
    output CommitCount
  );
endinterface

// File: rtl/writeback_register_file.sv
// Write-back stage + 32-entry register file with commit counter.
// Define WB_BYPASS_EN for same-cycle write-before-read forwarding.
module writeback_register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int COUNT_W  = 16
) (
  input logic clk,
  input logic Reset,
  writeback_register_file_if.slave bus
);

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic [DATA_W-1:0]  wb_data;
  logic               accept;
  logic [DATA_W-1:0]  rd1;
  logic [DATA_W-1:0]  rd2;

  assign wb_data = bus.MemoryReadEnableInput
                 ? bus.MemoryReadData
                 : bus.ALUResultInput;

  assign accept = bus.WriteBackEnableInput
               && (bus.DestinationRegisterInput != 5'd0);

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (accept) begin
      regs_q[bus.DestinationRegisterInput] <= wb_data;
      cnt_q <= cnt_d;
    end
  end

  // x0 reads as zero regardless of storage contents.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (bus.ReadRegister1 != 5'd0) begin
      rd1 = regs_q[bus.ReadRegister1];
    end
    if (bus.ReadRegister2 != 5'd0) begin
      rd2 = regs_q[bus.ReadRegister2];
    end
`ifdef WB_BYPASS_EN
    // accept already excludes x0, so x0 is never forwarded.
    if (Reset && accept
        && bus.ReadRegister1 == bus.DestinationRegisterInput) begin
      rd1 = wb_data;
    end
    if (Reset && accept
        && bus.ReadRegister2 == bus.DestinationRegisterInput) begin
      rd2 = wb_data;
    end
`endif
  end

  assign bus.ReadData1         = rd1;
  assign bus.ReadData2         = rd2;
  assign bus.WriteBackData     = wb_data;
  assign bus.WriteBackCommit   = accept;
  assign bus.WriteBackRegister = accept
                               ? bus.DestinationRegisterInput
                               : 5'd0;
  assign bus.CommitCount       = cnt_q;

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file (COUNT_W = 4).
// Honours WB_BYPASS_EN for the same-cycle read/write expectation.
module tb_writeback_register_file;

  logic clk;
  logic Reset;
  int   tests;
  int   fails;

  writeback_register_file_if #(.DATA_W(32), .COUNT_W(4)) bus ();

  writeback_register_file #(
    .DATA_W(32), .NUM_REGS(32), .COUNT_W(4)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.WriteBackEnableInput     = 1'b0;
    bus.MemoryReadEnableInput    = 1'b0;
    bus.ALUResultInput           = '0;
    bus.MemoryReadData           = '0;
    bus.DestinationRegisterInput = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    #2;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.WriteBackEnableInput     = 1'b1;
      bus.MemoryReadEnableInput    = 1'($urandom);
      bus.ALUResultInput           = $urandom;
      bus.MemoryReadData           = $urandom;
      bus.DestinationRegisterInput = 5'($urandom_range(1, 31));
      step();
    end
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      tests++;
      if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
        fails++;
        $display("FAIL reset_read[%0d] got %h/%h exp 0",
                 i, bus.ReadData1, bus.ReadData2);
      end
    end
    tests++;
    if (bus.CommitCount !== 4'd0) begin
      fails++;
      $display("FAIL reset_count got %0d exp 0", bus.CommitCount);
    end
    idle();
    step();
    Reset = 1'b1;
  endtask

  task automatic test_alu_writeback();
    bus.WriteBackEnableInput     = 1'b1;
    bus.MemoryReadEnableInput    = 1'b0;
    bus.ALUResultInput           = 32'h1234_5678;
    bus.MemoryReadData           = 32'hCAFE_0000;
    bus.DestinationRegisterInput = 5'd5;
    bus.ReadRegister1            = 5'd5;
    #1;
    tests++;
    if (bus.WriteBackCommit !== 1'b1) begin
      fails++;
      $display("FAIL alu_commit got %b exp 1", bus.WriteBackCommit);
    end
    tests++;
    if (bus.WriteBackRegister !== 5'd5) begin
      fails++;
      $display("FAIL alu_wbreg got %0d exp 5", bus.WriteBackRegister);
    end
    step();
    idle();
    #1;
    tests++;
    if (bus.ReadData1 !== 32'h1234_5678) begin
      fails++;
      $display("FAIL alu_read got %h exp 12345678", bus.ReadData1);
    end
    tests++;
    if (bus.CommitCount !== 4'd1) begin
      fails++;
      $display("FAIL alu_count got %0d exp 1", bus.CommitCount);
    end
  endtask

  task automatic test_load_select();
    bus.WriteBackEnableInput     = 1'b1;
    bus.MemoryReadEnableInput    = 1'b1;
    bus.MemoryReadData           = 32'hDEAD_BEEF;
    bus.ALUResultInput           = 32'h0000_0001;
    bus.DestinationRegisterInput = 5'd31;
    #1;
    tests++;
    if (bus.WriteBackData !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL load_wbdata got %h exp deadbeef", bus.WriteBackData);
    end
    step();
    idle();
    bus.ReadRegister1 = 5'd31;
    bus.ReadRegister2 = 5'd31;
    #1;
    tests++;
    if (bus.ReadData1 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL load_read got %h exp deadbeef", bus.ReadData1);
    end
    tests++;
    if (bus.ReadData2 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL both_ports got %h exp deadbeef", bus.ReadData2);
    end
    tests++;
    if (bus.CommitCount !== 4'd2) begin
      fails++;
      $display("FAIL load_count got %0d exp 2", bus.CommitCount);
    end
  endtask

  task automatic test_reg0_and_disabled();
    bus.WriteBackEnableInput     = 1'b1;
    bus.ALUResultInput           = 32'hFFFF_FFFF;
    bus.DestinationRegisterInput = 5'd0;
    bus.ReadRegister1            = 5'd0;
    #1;
    tests++;
    if (bus.WriteBackCommit !== 1'b0 || bus.WriteBackRegister !== 5'd0) begin
      fails++;
      $display("FAIL r0_commit got %b/%0d exp 0/0",
               bus.WriteBackCommit, bus.WriteBackRegister);
    end
    step();
    idle();
    #1;
    tests++;
    if (bus.ReadData1 !== 32'h0) begin
      fails++;
      $display("FAIL r0_read got %h exp 0", bus.ReadData1);
    end
    tests++;
    if (bus.CommitCount !== 4'd2) begin
      fails++;
      $display("FAIL r0_count got %0d exp 2", bus.CommitCount);
    end
    bus.WriteBackEnableInput     = 1'b0;
    bus.ALUResultInput           = 32'hAAAA_AAAA;
    bus.MemoryReadData           = 32'hAAAA_AAAA;
    bus.DestinationRegisterInput = 5'd7;
    bus.ReadRegister1            = 5'd7;
    #1;
    tests++;
    if (bus.WriteBackCommit !== 1'b0) begin
      fails++;
      $display("FAIL dis_commit got %b exp 0", bus.WriteBackCommit);
    end
    step();
    idle();
    #1;
    tests++;
    if (bus.ReadData1 !== 32'h0 || bus.CommitCount !== 4'd2) begin
      fails++;
      $display("FAIL dis_read got %h cnt %0d exp 0 cnt 2",
               bus.ReadData1, bus.CommitCount);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
`ifdef WB_BYPASS_EN
    exp_now = 32'h22;
`else
    exp_now = 32'h11;
`endif
    bus.WriteBackEnableInput     = 1'b1;
    bus.ALUResultInput           = 32'h11;
    bus.DestinationRegisterInput = 5'd9;
    step();
    bus.ALUResultInput = 32'h22;
    bus.ReadRegister2  = 5'd9;
    #1;
    tests++;
    if (bus.ReadData2 !== exp_now) begin
      fails++;
      $display("FAIL same_cycle got %h exp %h", bus.ReadData2, exp_now);
    end
    step();
    idle();
    #1;
    tests++;
    if (bus.ReadData2 !== 32'h22) begin
      fails++;
      $display("FAIL after_write got %h exp 22", bus.ReadData2);
    end
    tests++;
    if (bus.CommitCount !== 4'd4) begin
      fails++;
      $display("FAIL same_count got %0d exp 4", bus.CommitCount);
    end
  endtask

  task automatic test_counter_wrap();
    #2;
    Reset = 1'b0;
    #1;
    tests++;
    if (bus.CommitCount !== 4'd0) begin
      fails++;
      $display("FAIL pulse_count got %0d exp 0", bus.CommitCount);
    end
    step();
    Reset = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      bus.WriteBackEnableInput     = 1'b1;
      bus.ALUResultInput           = 32'h100 + 32'(i);
      bus.DestinationRegisterInput = 5'(i);
      step();
    end
    idle();
    bus.ReadRegister1 = 5'd17;
    bus.ReadRegister2 = 5'd1;
    #1;
    tests++;
    if (bus.CommitCount !== 4'd1) begin
      fails++;
      $display("FAIL wrap_count got %0d exp 1", bus.CommitCount);
    end
    tests++;
    if (bus.ReadData1 !== 32'h111 || bus.ReadData2 !== 32'h101) begin
      fails++;
      $display("FAIL wrap_regs got %h/%h exp 111/101",
               bus.ReadData1, bus.ReadData2);
    end
  endtask

  task automatic test_async_reset();
    bus.WriteBackEnableInput     = 1'b1;
    bus.ALUResultInput           = 32'h55;
    bus.DestinationRegisterInput = 5'd3;
    bus.ReadRegister1            = 5'd17;
    bus.ReadRegister2            = 5'd3;
    #2;
    Reset = 1'b0;
    #1;
    tests++;
    if (bus.CommitCount !== 4'd0 || bus.ReadData1 !== 32'h0) begin
      fails++;
      $display("FAIL async_clear got cnt %0d r17 %h exp 0/0",
               bus.CommitCount, bus.ReadData1);
    end
    tests++;
    if (bus.WriteBackCommit !== 1'b1 || bus.ReadData2 !== 32'h0) begin
      fails++;
      $display("FAIL rst_comb got commit %b r3 %h exp 1/0",
               bus.WriteBackCommit, bus.ReadData2);
    end
    step();
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      #1;
      tests++;
      if (bus.ReadData1 !== 32'h0) begin
        fails++;
        $display("FAIL async_read[%0d] got %h exp 0", i, bus.ReadData1);
      end
    end
    tests++;
    if (bus.CommitCount !== 4'd0) begin
      fails++;
      $display("FAIL async_count got %0d exp 0", bus.CommitCount);
    end
    idle();
    step();
    Reset = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    idle();
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    test_reset();
    test_alu_writeback();
    test_load_select();
    test_reg0_and_disabled();
    test_same_cycle();
    test_counter_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
